rep_serial_tx: RTL and testbench

- Transmit end of the repetition-code serial link; the receive end is a per-bit majority voter, such as the pair/triple detector.
- Accepts a parallel word over a val/rdy handshake.
- Serializes the word LSB first and emits each bit REPS consecutive times, so the receiver can majority-vote each group.
- Sits between a word producer and the serial channel.

---
 rtl/rep_serial_tx_if.sv | 30 +++
 rtl/rep_serial_tx.sv | 89 ++++++++
 tb/tb_rep_serial_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rep_serial_tx_if.sv
// rtl/rep_serial_tx_if.sv - word-in / serial-out signal bundle for rep_serial_tx
// master = word producer and serial sink side, slave = the transmitter itself
interface rep_serial_tx_if #(
   parameter int NBITS = 8
) ();
   logic             in_val;
   logic             in_rdy;
   logic [NBITS-1:0] in_data;
   logic             tx_val;
   logic             tx_bit;
   logic             tx_first;

   modport master (
      output in_val,
      output in_data,
      input  in_rdy,
      input  tx_val,
      input  tx_bit,
      input  tx_first
   );

   modport slave (
      input  in_val,
      input  in_data,
      output in_rdy,
      output tx_val,
      output tx_bit,
      output tx_first
   );
endinterface

// File: rtl/rep_serial_tx.sv
// rtl/rep_serial_tx.sv - LSB-first serializer sending each bit REPS times for a majority-vote receiver
// Optional trailing even-parity bit under macro REP_SERIAL_TX_PARITY_EN
module rep_serial_tx #(
   parameter int NBITS = 8,
   parameter int REPS  = 3
) (
   input  logic          clk,
   input  logic          reset,
   rep_serial_tx_if.slave bus
);

`ifdef REP_SERIAL_TX_PARITY_EN
   localparam int NSYM = NBITS + 1;
`else
   localparam int NSYM = NBITS;
`endif
   localparam int BW = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam int CW = (REPS > 1) ? $clog2(REPS) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(NSYM - 1);
   localparam logic [CW-1:0] LAST_COPY = CW'(REPS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state, state_nxt;
   logic [NSYM-1:0]   shreg, shreg_nxt;
   logic [BW-1:0]     bit_cnt, bit_nxt;
   logic [CW-1:0]     copy_cnt, copy_nxt;
   logic [NSYM-1:0]   load_word;
   logic              last_sym;
   logic              rdy;
   logic              xfer;

`ifdef REP_SERIAL_TX_PARITY_EN
   assign load_word = {^bus.in_data, bus.in_data};
`else
   assign load_word = bus.in_data;
`endif

   // Ready depends only on registered state (and reset), never on in_val.
   assign last_sym = (state == SEND) && (bit_cnt == LAST_BIT) && (copy_cnt == LAST_COPY);
   assign rdy      = reset && ((state == IDLE) || last_sym);
   assign xfer     = bus.in_val && rdy;

   assign bus.in_rdy   = rdy;
   assign bus.tx_val   = reset && (state == SEND);
   assign bus.tx_bit   = reset && (state == SEND) && shreg[0];
   assign bus.tx_first = reset && (state == SEND) && (bit_cnt == '0) && (copy_cnt == '0);

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bit_nxt   = bit_cnt;
      copy_nxt  = copy_cnt;
      if (xfer) begin
         state_nxt = SEND;
         shreg_nxt = load_word;
         bit_nxt   = '0;
         copy_nxt  = '0;
      end else if (state == SEND) begin
         if (copy_cnt == LAST_COPY) begin
            copy_nxt  = '0;
            shreg_nxt = shreg >> 1;
            if (last_sym) begin
               state_nxt = IDLE;
               bit_nxt   = '0;
            end else begin
               bit_nxt = bit_cnt + 1'b1;
            end
         end else begin
            copy_nxt = copy_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         copy_cnt <= '0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bit_cnt  <= bit_nxt;
         copy_cnt <= copy_nxt;
      end
   end

endmodule

// File: tb/tb_rep_serial_tx.sv
// tb/tb_rep_serial_tx.sv - randomized bench for rep_serial_tx with a symbol-queue reference model
// Parity symbols are expected when REP_SERIAL_TX_PARITY_EN is defined
module tb_rep_serial_tx;
   localparam int NBITS = 8;
   localparam int REPS  = 3;
`ifdef REP_SERIAL_TX_PARITY_EN
   localparam int NSYM = NBITS + 1;
`else
   localparam int NSYM = NBITS;
`endif
   localparam int NCYC = 3000;

   typedef struct {
      logic b;
      logic first;
      logic last;
      int   bidx;
      int   cidx;
   } sym_t;

   logic clk = 1'b0;
   logic reset;

   rep_serial_tx_if #(.NBITS(NBITS)) bus ();

   rep_serial_tx #(.NBITS(NBITS), .REPS(REPS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   sym_t             q[$];
   logic [NBITS-1:0] wq[$];
   logic [NBITS-1:0] tbl[6] = '{8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h01, 8'h5A};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected symbol stream for one word: each bit LSB first, REPS copies apiece.
   task automatic push_word(input logic [NBITS-1:0] w);
      sym_t s;
      for (int i = 0; i < NSYM; i++) begin
         for (int c = 0; c < REPS; c++) begin
            s.b     = (i < NBITS) ? w[i] : ^w;
            s.first = (i == 0) && (c == 0);
            s.last  = (i == NSYM - 1) && (c == REPS - 1);
            s.bidx  = i;
            s.cidx  = c;
            q.push_back(s);
         end
      end
      wq.push_back(w);
   endtask

   initial begin
      sym_t             s;
      logic             avail;
      logic             last_xfer;
      logic             xfer;
      logic             v;
      logic [NBITS-1:0] rec;
      int               ones;
      int               flip_c;
      int               rst_hold;
      int               di;

      reset     = 1'b0;
      bus.in_val  = 1'b0;
      bus.in_data = '0;
      rst_hold  = 2;
      di        = 0;
      last_xfer = 1'b0;
      ones      = 0;
      flip_c    = 0;
      rec       = '0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (!reset) begin
            check("rst_val", 32'(bus.tx_val), 0);
            check("rst_bit", 32'(bus.tx_bit), 0);
            check("rst_first", 32'(bus.tx_first), 0);
            check("rst_rdy", 32'(bus.in_rdy), 0);
            q.delete();
            wq.delete();
            avail = 1'b1;
         end else if (q.size() > 0) begin
            s = q.pop_front();
            check("tx_val", 32'(bus.tx_val), 1);
            check("tx_bit", 32'(bus.tx_bit), 32'(s.b));
            check("tx_first", 32'(bus.tx_first), 32'(s.first));
            check("in_rdy_send", 32'(bus.in_rdy), 32'(s.last));
            // receiver view: one copy per group corrupted, then majority vote
            if (s.cidx == 0) begin
               ones   = 0;
               flip_c = $urandom_range(0, REPS - 1);
            end
            if (s.bidx < NBITS) begin
               v = bus.tx_bit ^ (s.cidx == flip_c);
               ones += int'(v);
               if (s.cidx == REPS - 1)
                  rec[s.bidx] = (ones > REPS / 2);
            end
            if (s.last)
               check("loopback", 32'(rec), 32'(wq.pop_front()));
            avail = s.last;
         end else begin
            check("idle_val", 32'(bus.tx_val), 0);
            check("idle_bit", 32'(bus.tx_bit), 0);
            check("idle_first", 32'(bus.tx_first), 0);
            check("idle_rdy", 32'(bus.in_rdy), 1);
            avail = 1'b1;
         end

         // next-edge inputs
         if (!reset) begin
            if (rst_hold > 0) rst_hold--;
            else reset = 1'b1;
         end else if (di >= 6 && $urandom_range(0, 119) == 0) begin
            reset    = 1'b0;
            rst_hold = $urandom_range(0, 2);
         end

         if (last_xfer || !bus.in_val) begin
            if (di < 6) begin
               bus.in_val  = 1'b1;
               bus.in_data = tbl[di];
               di++;
            end else begin
               bus.in_val  = ($urandom_range(0, 2) != 0);
               bus.in_data = NBITS'($urandom);
            end
         end

         xfer = bus.in_val && reset && avail;
         if (xfer) push_word(bus.in_data);
         last_xfer = xfer;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
